// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller that sits in front of the shared
// alu_control + ALU pair. It accepts one MIPS-style operation over a
// valid/ready request port, decodes opcode/funct into alu_op/alu_funct,
// drives the ALU operands, captures result and zero flag, and returns them
// over a valid/ready response port.
//
// Optional feature macro: ALU_SEQ_OVF_EN
//   defined   -> signed overflow on add-class / sub-class ops raises rsp_err
//                (rsp_result still carries the ALU result)
//   undefined -> rsp_err is raised only by an illegal opcode/funct
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | req_ready=1, waiting for a request
// DECODE | decode captured opcode/funct, load alu_* registers
// EXEC   | ALU settles on registered operands, result captured at exit
// RESP   | rsp_valid=1, rsp_* held until rsp_ready

module alu_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_opcode,
  input  logic [5:0]        req_funct,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [1:0]        alu_op,
  output logic [5:0]        alu_funct,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic [5:0]          opcode_q, opcode_d;
  logic [5:0]          funct_q, funct_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                req_ready_q, req_ready_d;
  logic                busy_q, busy_d;
  logic [1:0]          alu_op_q, alu_op_d;
  logic [5:0]          alu_funct_q, alu_funct_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic                rsp_zero_q, rsp_zero_d;
  logic                rsp_err_q, rsp_err_d;

  logic                dec_legal;
  logic [1:0]          dec_alu_op;
  logic [5:0]          dec_alu_funct;
  logic                ovf;

  // Decode the captured opcode/funct into alu_control fields and legality.
  always_comb begin
    dec_legal     = 1'b0;
    dec_alu_op    = 2'b00;
    dec_alu_funct = 6'b000000;
    case (opcode_q)
      6'b000000: begin
        dec_alu_op    = 2'b10;
        dec_alu_funct = {2'b00, funct_q[3:0]};
        case (funct_q)
          6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: dec_legal = 1'b1;
          default: dec_legal = 1'b0;
        endcase
      end
      6'b100011, 6'b101011, 6'b001000: begin
        dec_alu_op = 2'b00;
        dec_legal  = 1'b1;
      end
      6'b000100: begin
        dec_alu_op = 2'b01;
        dec_legal  = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

`ifdef ALU_SEQ_OVF_EN
  logic is_add_cls;
  logic is_sub_cls;
  logic b_sign_eff;

  // Signed overflow on the live ALU result; B's sign is inverted for subtracts.
  always_comb begin
    is_add_cls = (alu_op_q == 2'b00) || (alu_op_q == 2'b10 && alu_funct_q == 6'b000000);
    is_sub_cls = (alu_op_q == 2'b01) || (alu_op_q == 2'b10 && alu_funct_q == 6'b000010);
    b_sign_eff = is_sub_cls ? ~alu_b_q[DATA_W-1] : alu_b_q[DATA_W-1];
    ovf        = (is_add_cls || is_sub_cls) &&
                 (alu_a_q[DATA_W-1] == b_sign_eff) &&
                 (alu_result[DATA_W-1] != alu_a_q[DATA_W-1]);
  end
`else
  assign ovf = 1'b0;
`endif

  // Next-state and next-output computation for the sequencer FSM.
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    funct_d      = funct_q;
    a_d          = a_q;
    b_d          = b_q;
    req_ready_d  = req_ready_q;
    busy_d       = busy_q;
    alu_op_d     = alu_op_q;
    alu_funct_d  = alu_funct_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          opcode_d    = req_opcode;
          funct_d     = req_funct;
          a_d         = req_a;
          b_d         = req_b;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = DECODE;
        end
      end
      DECODE: begin
        alu_op_d    = dec_alu_op;
        alu_funct_d = dec_alu_funct;
        alu_a_d     = a_q;
        alu_b_d     = b_q;
        if (dec_legal) begin
          state_d = EXEC;
        end else begin
          rsp_result_d = '0;
          rsp_zero_d   = 1'b0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_err_d    = ovf;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      opcode_q     <= '0;
      funct_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      alu_op_q     <= '0;
      alu_funct_q  <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      funct_q      <= funct_d;
      a_q          <= a_d;
      b_q          <= b_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      alu_op_q     <= alu_op_d;
      alu_funct_q  <= alu_funct_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign alu_op     = alu_op_q;
  assign alu_funct  = alu_funct_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: directed vector table, hand-written reset and
// back-to-back sequences, then random operations checked against a
// behavioural reference model. Provides its own alu_control + ALU stand-in.
// Honours ALU_SEQ_OVF_EN the same way the design does.

module tb_alu_sequencer;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [5:0]        req_opcode;
  logic [5:0]        req_funct;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [1:0]        alu_op;
  logic [5:0]        alu_funct;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_err;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_sequencer #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_funct(alu_funct),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for alu_control + ALU (classic MIPS encoding).
  always_comb begin
    alu_result = '0;
    case (alu_op)
      2'b00: alu_result = alu_a + alu_b;
      2'b01: alu_result = alu_a - alu_b;
      default: begin
        case (alu_funct[3:0])
          4'b0000: alu_result = alu_a + alu_b;
          4'b0010: alu_result = alu_a - alu_b;
          4'b0100: alu_result = alu_a & alu_b;
          4'b0101: alu_result = alu_a | alu_b;
          4'b1010: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
          default: alu_result = '0;
        endcase
      end
    endcase
    alu_zero = (alu_result == '0);
  end

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          stall;
    int          lat;
    logic [1:0]  aop;
    logic [5:0]  afn;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

`ifdef ALU_SEQ_OVF_EN
  localparam logic OVF_ERR = 1'b1;
`else
  localparam logic OVF_ERR = 1'b0;
`endif

  task automatic check(input string tag, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", tag, name, act, exp);
    end
  endtask

  // Reference: what the whole sequencer + ALU should report for one operation.
  task automatic ref_model(input logic [5:0] op, input logic [5:0] f,
                           input logic [31:0] a, input logic [31:0] b,
                           output vec_t v);
    longint sa, sb, s;
    int     cls;   // 0 none, 1 add-class, 2 sub-class
    bit     legal;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cls = 0;
    legal = 1'b1;
    v.op = op; v.f = f; v.a = a; v.b = b; v.stall = 0;
    v.aop = 2'd0; v.afn = 6'd0; v.res = 32'd0;
    if (op == 6'h00) begin
      v.aop = 2'd2;
      v.afn = {2'b00, f[3:0]};
      if (f == 6'h20) begin v.res = a + b; cls = 1; end
      else if (f == 6'h22) begin v.res = a - b; cls = 2; end
      else if (f == 6'h24) v.res = a & b;
      else if (f == 6'h25) v.res = a | b;
      else if (f == 6'h2A) v.res = (sa < sb) ? 32'd1 : 32'd0;
      else legal = 1'b0;
    end else if (op == 6'h23 || op == 6'h2B || op == 6'h08) begin
      v.res = a + b; cls = 1;
    end else if (op == 6'h04) begin
      v.aop = 2'd1; v.res = a - b; cls = 2;
    end else begin
      legal = 1'b0;
    end
    if (legal) begin
      v.lat  = 2;
      v.zero = (v.res == 32'd0);
      s = (cls == 2) ? sa - sb : sa + sb;
      v.err = (cls != 0 && (s > 64'sd2147483647 || s < -64'sd2147483648)) ? OVF_ERR : 1'b0;
    end else begin
      v.lat = 1; v.res = 32'd0; v.zero = 1'b0; v.err = 1'b1;
    end
  endtask

  // Issue one operation; must be called just after a falling edge with the DUT idle.
  // Returns just after the falling edge that follows the response handshake.
  task automatic run_op(input vec_t v, input string tag);
    int lat;
    req_opcode = v.op; req_funct = v.f; req_a = v.a; req_b = v.b;
    req_valid  = 1'b1;
    rsp_ready  = 1'($urandom);
    check(tag, "req_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid  = 1'b0;
    req_opcode = 6'($urandom); req_funct = 6'($urandom);
    req_a = $urandom; req_b = $urandom;
    check(tag, "busy_after_accept", {busy, req_ready, rsp_valid}, 3'b100);
    lat = 0;
    while (!rsp_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    rsp_ready = (v.stall == 0);
    check(tag, "latency", lat, v.lat);
    if (v.lat == 2) begin
      check(tag, "alu_op", alu_op, v.aop);
      check(tag, "alu_funct", alu_funct, v.afn);
      check(tag, "alu_ab", {alu_a, alu_b}, {v.a, v.b});
    end
    check(tag, "rsp_result", rsp_result, v.res);
    check(tag, "rsp_zero_err", {rsp_zero, rsp_err}, {v.zero, v.err});
    for (int i = 0; i < v.stall; i++) begin
      @(negedge clk);
      if (i == v.stall - 1) rsp_ready = 1'b1;
      check(tag, "held_under_stall",
            {rsp_valid, req_ready, busy, rsp_zero, rsp_err, rsp_result},
            {1'b1, 1'b0, 1'b1, v.zero, v.err, v.res});
    end
    @(negedge clk);
    check(tag, "after_handshake", {rsp_valid, req_ready, busy}, 3'b010);
    rsp_ready = 1'($urandom);
  endtask

  vec_t vecs[14];
  vec_t rv;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{6'h00, 6'h20, 32'd5,        32'd7,        0, 2, 2'd2, 6'h00, 32'd12,       1'b0, 1'b0};
    vecs[1]  = '{6'h04, 6'h2A, 32'h1234,     32'h1234,     0, 2, 2'd1, 6'h00, 32'd0,        1'b1, 1'b0};
    vecs[2]  = '{6'h04, 6'h00, 32'h1234,     32'h1235,     0, 2, 2'd1, 6'h00, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[3]  = '{6'h3F, 6'h20, 32'd1,        32'd2,        0, 1, 2'd0, 6'h00, 32'd0,        1'b0, 1'b1};
    vecs[4]  = '{6'h00, 6'h03, 32'd1,        32'd2,        0, 1, 2'd0, 6'h00, 32'd0,        1'b0, 1'b1};
    vecs[5]  = '{6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1,        5, 2, 2'd2, 6'h0A, 32'd1,        1'b0, 1'b0};
    vecs[6]  = '{6'h08, 6'h00, 32'h7FFFFFFF, 32'd1,        0, 2, 2'd0, 6'h00, 32'h80000000, 1'b0, OVF_ERR};
    vecs[7]  = '{6'h00, 6'h22, 32'd10,       32'd3,        1, 2, 2'd2, 6'h02, 32'd7,        1'b0, 1'b0};
    vecs[8]  = '{6'h00, 6'h24, 32'hF0F0,     32'hFF00,     0, 2, 2'd2, 6'h04, 32'hF000,     1'b0, 1'b0};
    vecs[9]  = '{6'h00, 6'h25, 32'hF0F0,     32'h0F0F,     2, 2, 2'd2, 6'h05, 32'hFFFF,     1'b0, 1'b0};
    vecs[10] = '{6'h23, 6'h11, 32'h100,      32'h20,       0, 2, 2'd0, 6'h00, 32'h120,      1'b0, 1'b0};
    vecs[11] = '{6'h2B, 6'h00, 32'd0,        32'd0,        0, 2, 2'd0, 6'h00, 32'd0,        1'b1, 1'b0};
    vecs[12] = '{6'h00, 6'h22, 32'd9,        32'd9,        0, 2, 2'd2, 6'h02, 32'd0,        1'b1, 1'b0};
    vecs[13] = '{6'h00, 6'h2A, 32'd1,        32'hFFFFFFFF, 0, 2, 2'd2, 6'h0A, 32'd0,        1'b1, 1'b0};

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_opcode = '0; req_funct = '0; req_a = '0; req_b = '0;
    @(negedge clk); @(negedge clk);
    check("reset", "ctrl", {req_ready, rsp_valid, busy, rsp_zero, rsp_err}, 5'b10000);
    check("reset", "alu_fields", {alu_op, alu_funct}, 8'd0);
    check("reset", "alu_ab", {alu_a, alu_b}, 64'd0);
    check("reset", "rsp_result", rsp_result, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table; successive entries run back-to-back, so each acceptance
    // lands one cycle after the previous response handshake.
    for (int i = 0; i < 14; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Reset while the operation is in EXEC: nothing must come out afterwards.
    req_opcode = 6'h00; req_funct = 6'h20; req_a = 32'd3; req_b = 32'd4;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_exec", "in_exec", {busy, rsp_valid, alu_op}, 4'b1010);
    #2 rst = 1'b1;
    #1;
    check("rst_exec", "ctrl", {req_ready, rsp_valid, busy, rsp_zero, rsp_err}, 5'b10000);
    check("rst_exec", "alu_fields", {alu_op, alu_funct}, 8'd0);
    check("rst_exec", "alu_ab", {alu_a, alu_b}, 64'd0);
    check("rst_exec", "rsp_result", rsp_result, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_exec", "no_response", {rsp_valid, req_ready, busy}, 3'b010);
    end
    run_op(vecs[0], "after_reset");

    // Random operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      logic [5:0]  op, f;
      logic [31:0] a, b;
      case ($urandom_range(0, 6))
        0, 1:    op = 6'h00;
        2:       op = 6'h23;
        3:       op = 6'h2B;
        4:       op = 6'h08;
        5:       op = 6'h04;
        default: op = 6'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: f = 6'h20;
        1: f = 6'h22;
        2: f = 6'h24;
        3: f = 6'h25;
        4: f = 6'h2A;
        default: f = 6'($urandom);
      endcase
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = {1'b0, 31'($urandom)};
        default: b = $urandom;
      endcase
      ref_model(op, f, a, b, rv);
      rv.stall = $urandom_range(0, 3);
      run_op(rv, $sformatf("rand%0d_op%02h_f%02h", i, op, f));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
